// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
//   Shared types and constants for the IF-stage fetch sequencer:
//   sequencer state encoding, instruction size in bytes and the default
//   reset PC.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_tag_pipe.sv
// fetch_tag_pipe
//   STAGES-deep shift register of {valid, pc} tags that follows each issued
//   fetch address across the fetch unit's fixed read latency. The head entry
//   lines up with the fetch unit output of the current cycle.
//
// Ports
//   system_clock  in   clock, rising edge
//   reset         in   asynchronous active-high reset (clears valids only)
//   flush         in   synchronous: invalidate every entry, including the one
//                      being inserted this cycle
//   insert_valid  in   valid bit of the tag entering stage 0
//   insert_pc     in   address of the tag entering stage 0
//   head_valid    out  valid bit of the oldest entry
//   head_pc       out  address of the oldest entry
module fetch_tag_pipe #(
    parameter int STAGES = 2,
    parameter int DATA_W = 32
) (
    input  logic              system_clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              insert_valid,
    input  logic [DATA_W-1:0] insert_pc,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_pc
);

    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] pc_p [STAGES];

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= insert_valid;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Address payload carries no reset; its meaning is gated by vld_p.
    always_ff @(posedge system_clock) begin
        pc_p[0] <= insert_pc;
        for (int i = 1; i < STAGES; i++) begin
            pc_p[i] <= pc_p[i-1];
        end
    end

    assign head_valid = vld_p[STAGES-1];
    assign head_pc    = pc_p[STAGES-1];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program-counter sequencer and fetch controller for the IF stage. Issues
//   program_counter to the fetch unit, tracks in-flight addresses through
//   fetch_tag_pipe, and loads IF/ID with {pc, instruction}. Decode stalls
//   freeze IF/ID and replay from the next PC; redirects squash all younger
//   work and restart from the target.
//
//   Optional feature: define FETCH_PERF_COUNT_EN to build the saturating
//   bubble_cycles / redirect_count counters. Without it both ports read 0.
//
// Ports
//   system_clock       in   clock, rising edge
//   reset              in   asynchronous active-high reset
//   stall              in   decode cannot accept (honoured only if if_id_valid)
//   redirect_valid     in   taken branch/jump, priority over stall
//   redirect_target    in   new PC (word aligned)
//   fetch_valid        in   fetch unit output valid
//   fetch_instruction  in   fetch unit output word
//   program_counter    out  address presented to the fetch unit
//   if_id_valid        out  IF/ID holds a real instruction
//   if_id_pc           out  PC of the held instruction
//   if_id_instruction  out  held instruction word
//   bubble_cycles      out  perf: cycles with if_id_valid=0
//   redirect_count     out  perf: redirects taken
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int          FETCH_LATENCY = 2
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instruction,
    output logic [31:0] program_counter,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] bubble_cycles,
    output logic [15:0] redirect_count
);

    localparam logic [3:0] FILL_LAST = 4'(FETCH_LATENCY - 1);

    seq_state_t  state, state_nx;
    logic [3:0]  fill_cnt, fill_cnt_nx;
    logic [31:0] pc_nx;
    logic        if_id_valid_nx;
    logic [31:0] if_id_pc_nx;
    logic [31:0] if_id_instruction_nx;
    logic        tag_flush;
    logic        tag_insert;
    logic        head_valid;
    logic [31:0] head_pc;

    fetch_tag_pipe #(
        .STAGES (FETCH_LATENCY),
        .DATA_W (32)
    ) u_tag_pipe (
        .system_clock (system_clock),
        .reset        (reset),
        .flush        (tag_flush),
        .insert_valid (tag_insert),
        .insert_pc    (program_counter),
        .head_valid   (head_valid),
        .head_pc      (head_pc)
    );

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state             <= ST_FILL;
            fill_cnt          <= '0;
            program_counter   <= RESET_PC;
            if_id_valid       <= 1'b0;
            if_id_pc          <= '0;
            if_id_instruction <= '0;
        end else begin
            state             <= state_nx;
            fill_cnt          <= fill_cnt_nx;
            program_counter   <= pc_nx;
            if_id_valid       <= if_id_valid_nx;
            if_id_pc          <= if_id_pc_nx;
            if_id_instruction <= if_id_instruction_nx;
        end
    end

    always_comb begin
        state_nx             = state;
        fill_cnt_nx          = fill_cnt;
        pc_nx                = program_counter;
        if_id_valid_nx       = if_id_valid;
        if_id_pc_nx          = if_id_pc;
        if_id_instruction_nx = if_id_instruction;
        tag_flush            = 1'b0;
        tag_insert           = 1'b0;

        if (redirect_valid) begin
            state_nx       = ST_FILL;
            fill_cnt_nx    = '0;
            pc_nx          = redirect_target;
            if_id_valid_nx = 1'b0;
            tag_flush      = 1'b1;
        end else if (stall && if_id_valid) begin
            // Entering or staying in HOLD: IF/ID frozen, in-flight fetches
            // discarded, replay starts at the instruction after the held one.
            state_nx  = ST_HOLD;
            pc_nx     = if_id_pc + INSTR_BYTES;
            tag_flush = 1'b1;
        end else begin
            unique case (state)
                ST_FILL: begin
                    pc_nx      = program_counter + INSTR_BYTES;
                    tag_insert = 1'b1;
                    if (fill_cnt == FILL_LAST) begin
                        state_nx = ST_RUN;
                    end else begin
                        fill_cnt_nx = fill_cnt + 4'd1;
                    end
                end
                ST_RUN: begin
                    pc_nx      = program_counter + INSTR_BYTES;
                    tag_insert = 1'b1;
                    if (head_valid && fetch_valid) begin
                        if_id_valid_nx       = 1'b1;
                        if_id_pc_nx          = head_pc;
                        if_id_instruction_nx = fetch_instruction;
                    end else begin
                        if_id_valid_nx = 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Stall released: refill from the held PC.
                    state_nx       = ST_FILL;
                    fill_cnt_nx    = '0;
                    if_id_valid_nx = 1'b0;
                end
                default: begin
                    state_nx = ST_FILL;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [31:0] bubble_q;
    logic [15:0] redirect_q;

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            bubble_q   <= '0;
            redirect_q <= '0;
        end else begin
            if (!if_id_valid) begin
                bubble_q <= sat_inc32(bubble_q);
            end
            if (redirect_valid) begin
                redirect_q <= sat_inc16(redirect_q);
            end
        end
    end

    assign bubble_cycles  = bubble_q;
    assign redirect_count = redirect_q;
`else
    assign bubble_cycles  = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer and fetch controller for the IF stage of the MIPS pipeline. Drives `program_counter` into the instruction fetch unit, tracks which issued addresses are still in flight across the fetch unit's fixed read latency, and presents instructions with their PCs to the IF/ID register. Handles decode stalls (replay) and branch/jump redirects (flush) from later stages.

## Interface
- `RESET_PC`, 32'h0000_0000, PC issued first after reset
- `FETCH_LATENCY`, 2, cycles from `program_counter` presented to matching `fetch_instruction` on fetch unit output (legal 1..8)

- `system_clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  decode cannot accept; meaningful only while `if_id_valid`=1
- `redirect_valid`  in  1  branch/jump taken, squash all younger work
- `redirect_target`  in  32  new PC, word aligned
- `fetch_valid`  in  1  fetch unit `valid`
- `fetch_instruction`  in  32  fetch unit `instruction`
- `program_counter`  out  32  address to fetch unit
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_pc`  out  32  PC of held instruction
- `if_id_instruction`  out  32  held instruction word
- `bubble_cycles`  out  32  perf: cycles with `if_id_valid`=0 (see Configuration)
- `redirect_count`  out  16  perf: redirects taken

## Operation
- Tag pipe: FETCH_LATENCY-deep shift register of {tag_valid, tag_pc}; every cycle shifts, head entry matches current `fetch_instruction`.
- States: FILL, RUN, HOLD.
- FILL: PC advances +4/cycle, valid tags inserted; refill counter counts FETCH_LATENCY cycles, then RUN. Entered from reset, redirect, stall release.
- RUN: PC advances +4/cycle, valid tags inserted. Capture when head tag_valid & `fetch_valid`: `if_id_*` <= {1, head pc, `fetch_instruction`}. Head valid but `fetch_valid`=0: `if_id_valid`<=0, entry dropped.
- HOLD: entered when `stall`=1 and `if_id_valid`=1 (any state). `if_id_*` frozen; all tags invalidated; `program_counter` <= `if_id_pc`+4 and held; invalid tags inserted. On `stall`=0: FILL from held PC, `if_id_valid`<=0 until first refilled instruction captured.
- Redirect (any state, priority over stall): `program_counter` <= `redirect_target`, all tags invalidated, `if_id_valid`<=0, refill counter cleared, state FILL.
- `stall` with `if_id_valid`=0 ignored.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: `program_counter`=RESET_PC, `if_id_valid`=0, `if_id_pc`=0, `if_id_instruction`=0, all tags invalid, state FILL, perf counters 0.
- First issue: cycle after reset deassert, PC=RESET_PC; captured into IF/ID at edge FETCH_LATENCY+1 cycles later.
- Steady RUN: one instruction/cycle, PCs consecutive.
- Redirect penalty: FETCH_LATENCY+1 cycles of `if_id_valid`=0; stall replay penalty identical after release.
- Redirect during FILL restarts counter; redirect same cycle as stall release → redirect target wins.
- Reset mid-operation returns to reset values asynchronously.

## Configuration
- `FETCH_PERF_COUNT_EN` defined: `bubble_cycles` increments each cycle `if_id_valid`=0 outside reset, saturating at 32'hFFFF_FFFF; `redirect_count` increments per accepted redirect, saturating at 16'hFFFF.
- Undefined: both ports present, driven constant 0, no counter flops.

## Structure
- Package `fetch_seq_pkg`: state enum (FILL, RUN, HOLD), `INSTR_BYTES`=4, default RESET_PC constant.
- Sub-module `fetch_tag_pipe`: parameterised {valid,pc} shift register with synchronous flush; sequencer FSM and PC logic stay top level.

## Test plan
- Reset, RESET_PC=0, FETCH_LATENCY=2, model memory word=addr -> `if_id_pc` 0,4,8… from cycle 3 with `if_id_instruction`=`if_id_pc`, no gaps.
- In RUN, pulse redirect to 32'h0000_0100 -> `if_id_valid`=0 for 3 cycles, next captured pc=0x100, then 0x104.
- Stall 4 cycles while holding pc=0x20 -> `if_id` fixed at 0x20 for stall, after release 3 bubbles then pc=0x24; no duplicate or skipped PC.
- Redirect and stall asserted together with pc=0x40 held, target 0x200 -> stall ignored, next valid pc=0x200.
- Redirect to 32'hFFFF_FFF8 -> captured sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With `FETCH_PERF_COUNT_EN`: reset then two redirects -> `redirect_count`=2, `bubble_cycles`=9 (3 initial + 3 + 3); without macro both read 0.
